// File: rtl/id_pkg.sv
// Shared decode constants, control payload and condition evaluation for the ID stage.
package id_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned COND_W = 4;
  localparam int unsigned OPC_W  = 4;

  // Execute-unit command encodings
  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_TST = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_LDR = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_STR = 4'b0010;

  localparam logic [MODE_W-1:0] MODE_DP  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_MEM = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BR  = 2'b10;

  // Instruction opcode field values (instr[24:21])
  localparam logic [OPC_W-1:0] OP_AND = 4'b0000;
  localparam logic [OPC_W-1:0] OP_EOR = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADC = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SBC = 4'b0110;
  localparam logic [OPC_W-1:0] OP_TST = 4'b1000;
  localparam logic [OPC_W-1:0] OP_CMP = 4'b1010;
  localparam logic [OPC_W-1:0] OP_ORR = 4'b1100;
  localparam logic [OPC_W-1:0] OP_MOV = 4'b1101;
  localparam logic [OPC_W-1:0] OP_MVN = 4'b1111;

  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             b;
    logic             s;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // nzcv = {N,Z,C,V}; unlisted codes (AL and 1111) always pass
  function automatic logic cond_pass(input logic [COND_W-1:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    {n, z, c, v} = nzcv;
    ok = 1'b1;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_CS: ok = c;
      COND_CC: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_piped_decode_ctrl.sv
// Control decode of mode/opcode/S into the EX control payload, plus condition check.
module decode_ctrl
  import id_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              s_bit,
  input  logic [COND_W-1:0] cond,
  input  logic [3:0]        status_reg,
  output ctrl_t             ctrl_c,
  output logic              cond_ok_c
);

  always_comb begin
    ctrl_c = CTRL_BUBBLE;
    case (mode)
      MODE_DP: begin
        ctrl_c.wb_en = 1'b1;
        ctrl_c.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl_c.cmd = CMD_MOV;
          OP_MVN: ctrl_c.cmd = CMD_MVN;
          OP_ADD: ctrl_c.cmd = CMD_ADD;
          OP_ADC: ctrl_c.cmd = CMD_ADC;
          OP_SUB: ctrl_c.cmd = CMD_SUB;
          OP_SBC: ctrl_c.cmd = CMD_SBC;
          OP_AND: ctrl_c.cmd = CMD_AND;
          OP_ORR: ctrl_c.cmd = CMD_ORR;
          OP_EOR: ctrl_c.cmd = CMD_EOR;
          OP_CMP: begin
            ctrl_c.cmd   = CMD_CMP;
            ctrl_c.wb_en = 1'b0;
          end
          OP_TST: begin
            ctrl_c.cmd   = CMD_TST;
            ctrl_c.wb_en = 1'b0;
          end
          default: ctrl_c.cmd = CMD_NOP;
        endcase
      end
      // S selects load vs store; flags are never updated by memory ops
      MODE_MEM: begin
        ctrl_c.mem_read  = s_bit;
        ctrl_c.wb_en     = s_bit;
        ctrl_c.mem_write = !s_bit;
        ctrl_c.cmd       = s_bit ? CMD_LDR : CMD_STR;
      end
      MODE_BR: ctrl_c.b = 1'b1;
      default: ctrl_c.s = s_bit;
    endcase
  end

  assign cond_ok_c = cond_pass(cond, status_reg);

endmodule

// File: rtl/id_stage_piped.sv
// Decode stage: field extraction, bypassed register file, RAW hazard detection and the ID/EX register.
module id_stage_piped
  import id_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned REG_COUNT     = 16,
  parameter int unsigned FORWARDING_EN = 0,
  parameter int unsigned REG_ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] pc_in,
  input  logic [31:0]           instr_in,
  input  logic [3:0]            status_reg,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [WORD_WIDTH-1:0] wb_value,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  hazard,
  output logic [WORD_WIDTH-1:0] ex_pc,
  output logic [WORD_WIDTH-1:0] ex_val_rn,
  output logic [WORD_WIDTH-1:0] ex_val_rm,
  output logic [23:0]           ex_imm24,
  output logic [11:0]           ex_shift_op,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [3:0]            ex_cmd,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_en,
  output logic                  ex_imm,
  output logic                  ex_b,
  output logic                  ex_s
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(REG_COUNT - 1);

  logic [MODE_W-1:0]     mode_c;
  logic [OPC_W-1:0]      opcode_c;
  logic                  imm_c;
  logic [REG_ADDR_W-1:0] src1_c, src2_c, dst_c;
  ctrl_t                 ctrl_c;
  logic                  cond_ok_c;

  assign mode_c   = instr_in[27:26];
  assign opcode_c = instr_in[24:21];
  assign imm_c    = instr_in[25];
  assign dst_c    = REG_ADDR_W'(instr_in[15:12]);
  assign src1_c   = REG_ADDR_W'(instr_in[19:16]);
  assign src2_c   = ctrl_c.mem_write ? dst_c : REG_ADDR_W'(instr_in[3:0]);

  decode_ctrl u_decode_ctrl (
    .mode       (mode_c),
    .opcode     (opcode_c),
    .s_bit      (instr_in[20]),
    .cond       (instr_in[31:28]),
    .status_reg (status_reg),
    .ctrl_c     (ctrl_c),
    .cond_ok_c  (cond_ok_c)
  );

  // Register file; the PC slot is never written
  logic [WORD_WIDTH-1:0] rf [REG_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) rf[i] <= '0;
    end else if (wb_en && (wb_dest != PC_ADDR)) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // Read ports: PC slot returns pc_in, otherwise a same-cycle write is bypassed
  logic [WORD_WIDTH-1:0] val_rn_c, val_rm_c;

  always_comb begin
    val_rn_c = rf[src1_c];
    val_rm_c = rf[src2_c];
    if (src1_c == PC_ADDR)                  val_rn_c = pc_in;
    else if (wb_en && (wb_dest == src1_c))  val_rn_c = wb_value;
    if (src2_c == PC_ADDR)                  val_rm_c = pc_in;
    else if (wb_en && (wb_dest == src2_c))  val_rm_c = wb_value;
  end

  logic use_src1_c, use_src2_c, exe_hit_c, mem_hit_c;

  always_comb begin
    use_src1_c = (mode_c != MODE_BR) &&
                 !((mode_c == MODE_DP) && ((opcode_c == OP_MOV) || (opcode_c == OP_MVN))) &&
                 (src1_c != PC_ADDR);
    use_src2_c = (((mode_c == MODE_DP) && !imm_c) || ctrl_c.mem_write) && (src2_c != PC_ADDR);
    exe_hit_c  = (use_src1_c && (src1_c == exe_dest)) || (use_src2_c && (src2_c == exe_dest));
    mem_hit_c  = (use_src1_c && (src1_c == mem_dest)) || (use_src2_c && (src2_c == mem_dest));
    if (FORWARDING_EN != 0) hazard = exe_hit_c && exe_mem_read;
    else                    hazard = (exe_hit_c && exe_wb_en) || (mem_hit_c && mem_wb_en);
    if (flush) hazard = 1'b0;
  end

  // ID/EX register: flush beats freeze; bubbles clear control only
  ctrl_t ex_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_val_rn   <= '0;
      ex_val_rm   <= '0;
      ex_imm24    <= '0;
      ex_shift_op <= '0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_dst      <= '0;
      ex_imm      <= 1'b0;
    end else if (flush || !freeze) begin
      ex_ctrl     <= (flush || hazard || !cond_ok_c) ? CTRL_BUBBLE : ctrl_c;
      ex_pc       <= pc_in;
      ex_val_rn   <= val_rn_c;
      ex_val_rm   <= val_rm_c;
      ex_imm24    <= instr_in[23:0];
      ex_shift_op <= instr_in[11:0];
      ex_src1     <= src1_c;
      ex_src2     <= src2_c;
      ex_dst      <= dst_c;
      ex_imm      <= imm_c;
    end
  end

  assign ex_cmd       = ex_ctrl.cmd;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_wb_en     = ex_ctrl.wb_en;
  assign ex_b         = ex_ctrl.b;
  assign ex_s         = ex_ctrl.s;

endmodule

// File: tb/tb_id_stage_piped.sv
// Directed bench for id_stage_piped: vector table plus freeze-hold and reset-during-stall sequences.
module tb_id_stage_piped;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [3:0] AL = 4'hE;
  localparam logic [3:0] EQ = 4'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, flush;
  logic [31:0] pc_in, instr_in;
  logic [3:0]  status_reg;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en, exe_mem_read;
  logic [3:0]  exe_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;

  logic        hazard;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [23:0] ex_imm24;
  logic [11:0] ex_shift_op;
  logic [3:0]  ex_src1, ex_src2, ex_dst, ex_cmd;
  logic        ex_mem_read, ex_mem_write, ex_wb_en, ex_imm, ex_b, ex_s;

  logic        f_hazard;
  logic [31:0] f_ex_pc, f_ex_val_rn, f_ex_val_rm;
  logic [23:0] f_ex_imm24;
  logic [11:0] f_ex_shift_op;
  logic [3:0]  f_ex_src1, f_ex_src2, f_ex_dst, f_ex_cmd;
  logic        f_ex_mem_read, f_ex_mem_write, f_ex_wb_en, f_ex_imm, f_ex_b, f_ex_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage_piped #(.WORD_WIDTH(32), .REG_COUNT(16), .FORWARDING_EN(0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .pc_in(pc_in), .instr_in(instr_in),
    .status_reg(status_reg), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_imm24(ex_imm24),
    .ex_shift_op(ex_shift_op), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
    .ex_cmd(ex_cmd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wb_en(ex_wb_en), .ex_imm(ex_imm), .ex_b(ex_b), .ex_s(ex_s)
  );

  id_stage_piped #(.WORD_WIDTH(32), .REG_COUNT(16), .FORWARDING_EN(1)) dut_fw (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .pc_in(pc_in), .instr_in(instr_in),
    .status_reg(status_reg), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(f_hazard),
    .ex_pc(f_ex_pc), .ex_val_rn(f_ex_val_rn), .ex_val_rm(f_ex_val_rm), .ex_imm24(f_ex_imm24),
    .ex_shift_op(f_ex_shift_op), .ex_src1(f_ex_src1), .ex_src2(f_ex_src2), .ex_dst(f_ex_dst),
    .ex_cmd(f_ex_cmd), .ex_mem_read(f_ex_mem_read), .ex_mem_write(f_ex_mem_write),
    .ex_wb_en(f_ex_wb_en), .ex_imm(f_ex_imm), .ex_b(f_ex_b), .ex_s(f_ex_s)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  st;
    logic        wbe;
    logic [3:0]  wbd;
    logic [31:0] wbv;
    logic        xwe, xmr;
    logic [3:0]  xd;
    logic        mwe;
    logic [3:0]  md;
    logic        fl, fz, haz, hfw;
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s;
    logic [31:0] rn, rm;
    logic [3:0]  dst;
  } vec_t;

  vec_t v [17];

  function automatic logic [31:0] mk_dp(input logic [3:0] c, input logic i, input logic [3:0] op,
                                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] op2);
    return {c, 2'b00, i, op, s, rn, rd, op2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    freeze = N; flush = N; status_reg = 4'h0;
    wb_en = N; wb_dest = 4'd0; wb_value = 32'h0;
    exe_wb_en = N; exe_mem_read = N; exe_dest = 4'd0;
    mem_wb_en = N; mem_dest = 4'd0;
    instr_in = 32'h0;
  endtask

  task automatic rf_write(input logic [3:0] a, input logic [31:0] d);
    wb_en = Y; wb_dest = a; wb_value = d;
    @(posedge clk); #1;
    wb_en = N;
  endtask

  logic [31:0] add123, sub_i;

  initial begin
    add123 = mk_dp(AL, N, 4'b0100, N, 4'd2, 4'd1, 12'h003);
    //            instr                                         st    wbe wbd   wbv        xwe xmr xd    mwe md    fl fz haz hfw cmd   wb mr mw b  s   rn          rm          dst
    v[0]  = '{add123,                                        4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h2, Y, N, N, N, N, 32'h5,      32'h7,      4'd1};
    v[1]  = '{mk_dp(AL, N, 4'b0010, Y, 4'd2, 4'd4, 12'h003), 4'h0, Y, 4'd2, 32'h55,    N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h4, Y, N, N, N, Y, 32'h55,     32'h7,      4'd4};
    v[2]  = '{add123,                                        4'h0, N, 4'd0, 32'h0,     Y, N, 4'd2,  N, 4'd0,  N, N, Y, N, 4'h0, N, N, N, N, N, 32'h55,     32'h7,      4'd1};
    v[3]  = '{add123,                                        4'h0, N, 4'd0, 32'h0,     Y, Y, 4'd3,  N, 4'd0,  N, N, Y, Y, 4'h0, N, N, N, N, N, 32'h55,     32'h7,      4'd1};
    v[4]  = '{add123,                                        4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  Y, 4'd3,  N, N, Y, N, 4'h0, N, N, N, N, N, 32'h55,     32'h7,      4'd1};
    v[5]  = '{mk_dp(AL, Y, 4'b1101, N, 4'd2, 4'd6, 12'h0AB), 4'h0, N, 4'd0, 32'h0,     Y, N, 4'd2,  N, 4'd0,  N, N, N, N, 4'h1, Y, N, N, N, N, 32'h55,     32'h0,      4'd6};
    v[6]  = '{mk_dp(AL, N, 4'b1010, Y, 4'd2, 4'd0, 12'h003), 4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h4, N, N, N, N, Y, 32'h55,     32'h7,      4'd0};
    v[7]  = '{mk_dp(AL, N, 4'b1100, N, 4'd3, 4'd8, 12'h002), 4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h7, Y, N, N, N, N, 32'h7,      32'h55,     4'd8};
    v[8]  = '{mk_dp(EQ, N, 4'b0100, Y, 4'd2, 4'd1, 12'h003), 4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h0, N, N, N, N, N, 32'h55,     32'h7,      4'd1};
    v[9]  = '{mk_dp(EQ, N, 4'b0100, Y, 4'd2, 4'd1, 12'h003), 4'h4, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h2, Y, N, N, N, Y, 32'h55,     32'h7,      4'd1};
    v[10] = '{{AL, 2'b01, 1'b0, 4'b0100, 1'b1, 4'd5, 4'd7, 12'h004},
                                                             4'h0, N, 4'd0, 32'h0,     Y, N, 4'd4,  N, 4'd0,  N, N, N, N, 4'h2, Y, Y, N, N, N, 32'h20,     32'h0,      4'd7};
    v[11] = '{{AL, 2'b01, 1'b0, 4'b0100, 1'b0, 4'd5, 4'd3, 12'h004},
                                                             4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h2, N, N, Y, N, N, 32'h20,     32'h7,      4'd3};
    v[12] = '{{AL, 2'b01, 1'b0, 4'b0100, 1'b0, 4'd5, 4'd3, 12'h004},
                                                             4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  Y, 4'd3,  N, N, Y, N, 4'h0, N, N, N, N, N, 32'h20,     32'h7,      4'd3};
    v[13] = '{32'hEA000010,                                  4'h0, N, 4'd0, 32'h0,     Y, N, 4'd0,  N, 4'd0,  N, N, N, N, 4'h0, N, N, N, Y, N, 32'h0,      32'h0,      4'd0};
    v[14] = '{mk_dp(AL, N, 4'b0100, N, 4'd15, 4'd1, 12'h003),4'h0, Y, 4'd15,32'hDEAD,  Y, N, 4'd15, Y, 4'd15, N, N, N, N, 4'h2, Y, N, N, N, N, 32'h1000,   32'h7,      4'd1};
    v[15] = '{add123,                                        4'h0, N, 4'd0, 32'h0,     Y, Y, 4'd2,  N, 4'd0,  Y, Y, N, N, 4'h0, N, N, N, N, N, 32'h55,     32'h7,      4'd1};
    v[16] = '{mk_dp(AL, Y, 4'b0001, Y, 4'd3, 4'd9, 12'h0FF), 4'h0, N, 4'd0, 32'h0,     N, N, 4'd0,  Y, 4'd2,  N, N, N, N, 4'h8, Y, N, N, N, Y, 32'h7,      32'h1000,   4'd9};

    idle_inputs();
    pc_in = 32'h1000;
    rst = 1'b0;
    #2;
    chk("reset ex_pc", ex_pc, 32'h0);
    chk("reset ex_val_rn", ex_val_rn, 32'h0);
    chk("reset ex_cmd", 32'(ex_cmd), 32'h0);
    chk("reset ctrl", 32'({ex_mem_read, ex_mem_write, ex_wb_en, ex_b, ex_s, ex_imm}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    rf_write(4'd2, 32'h5);
    rf_write(4'd3, 32'h7);
    rf_write(4'd5, 32'h20);

    for (int i = 0; i < 17; i++) begin
      instr_in = v[i].instr; status_reg = v[i].st;
      wb_en = v[i].wbe; wb_dest = v[i].wbd; wb_value = v[i].wbv;
      exe_wb_en = v[i].xwe; exe_mem_read = v[i].xmr; exe_dest = v[i].xd;
      mem_wb_en = v[i].mwe; mem_dest = v[i].md;
      flush = v[i].fl; freeze = v[i].fz;
      #1;
      chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(v[i].haz));
      chk($sformatf("v%0d hazard_fwd", i), 32'(f_hazard), 32'(v[i].hfw));
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_cmd", i), 32'(ex_cmd), 32'(v[i].cmd));
      chk($sformatf("v%0d ctrl", i), 32'({ex_wb_en, ex_mem_read, ex_mem_write, ex_b, ex_s}),
          32'({v[i].wb, v[i].mr, v[i].mw, v[i].b, v[i].s}));
      chk($sformatf("v%0d ex_val_rn", i), ex_val_rn, v[i].rn);
      chk($sformatf("v%0d ex_val_rm", i), ex_val_rm, v[i].rm);
      chk($sformatf("v%0d ex_dst", i), 32'(ex_dst), 32'(v[i].dst));
    end

    // Condition-fail bubble, then freeze holds it for three cycles
    idle_inputs();
    instr_in = mk_dp(EQ, N, 4'b0100, N, 4'd2, 4'd1, 12'h123);
    @(posedge clk); #1;
    chk("cfail ex_cmd", 32'(ex_cmd), 32'h0);
    chk("cfail ex_wb_en", 32'(ex_wb_en), 32'h0);
    chk("cfail ex_shift_op", 32'(ex_shift_op), 32'h123);
    sub_i = mk_dp(AL, N, 4'b0010, Y, 4'd5, 4'd4, 12'h002);
    instr_in = sub_i; freeze = Y; pc_in = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("freeze%0d ex_pc", k), ex_pc, 32'h1000);
      chk($sformatf("freeze%0d ex_val_rn", k), ex_val_rn, 32'h55);
      chk($sformatf("freeze%0d ex_shift_op", k), 32'(ex_shift_op), 32'h123);
      chk($sformatf("freeze%0d ctrl", k), 32'({ex_cmd, ex_wb_en, ex_s, ex_dst}), 32'({4'h0, N, N, 4'd1}));
    end
    freeze = N;
    @(posedge clk); #1;
    chk("unfreeze ex_cmd", 32'(ex_cmd), 32'h4);
    chk("unfreeze ex_s", 32'(ex_s), 32'h1);
    chk("unfreeze ex_pc", ex_pc, 32'h2000);
    chk("unfreeze ex_val_rn", ex_val_rn, 32'h20);
    chk("unfreeze ex_imm24", 32'(ex_imm24), 32'h554002);
    chk("unfreeze ex_src2", 32'(ex_src2), 32'h2);

    // Async reset while stalled on a hazard
    instr_in = add123; exe_wb_en = Y; exe_dest = 4'd2; freeze = Y;
    #1;
    chk("stall hazard", 32'(hazard), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("midreset ex_wb_en", 32'(ex_wb_en), 32'h0);
    chk("midreset ex_val_rn", ex_val_rn, 32'h0);
    chk("midreset ex_pc", ex_pc, 32'h0);
    chk("midreset hazard", 32'(hazard), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; exe_wb_en = N; freeze = N;
    @(posedge clk); #1;
    chk("postreset ex_val_rn", ex_val_rn, 32'h0);
    chk("postreset R3", ex_val_rm, 32'h0);
    chk("postreset ex_cmd", 32'(ex_cmd), 32'h2);
    chk("postreset ex_wb_en", 32'(ex_wb_en), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage_piped.md
# id_stage_piped

Parametrised decode stage with an integrated ID/EX pipeline register, a register file with write-through bypass, and hazard detection. It sits between the IF/ID register and the execute stage. It decodes the 32-bit instruction, reads operands (R15 reads return `pc_in`), and checks the condition code. It also detects read-after-write hazards against the EX and MEM stages and produces a registered bundle for EX. It supports freeze, flush and a forwarding-aware hazard mode.

## Interface
- `WORD_WIDTH`, 32, datapath and register width
- `REG_COUNT`, 16, architectural registers; `REG_ADDR_W = $clog2(REG_COUNT)`; the PC is register `REG_COUNT-1`
- `FORWARDING_EN`, 0, 1 = stall only on load-use; 0 = stall on any EX/MEM RAW hazard

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `freeze` in 1: global stall; ID/EX holds
- `flush` in 1: branch taken in EX; ID/EX loads a bubble
- `pc_in` in WORD_WIDTH: PC+4 from IF/ID
- `instr_in` in 32: instruction from IF/ID
- `status_reg` in 4: {N,Z,C,V}
- `wb_en` in 1: register-file write enable
- `wb_dest` in REG_ADDR_W: write address
- `wb_value` in WORD_WIDTH: write data
- `exe_wb_en`, `exe_mem_read` in 1 each: EX-stage control
- `exe_dest` in REG_ADDR_W: EX-stage destination
- `mem_wb_en` in 1: MEM-stage write enable
- `mem_dest` in REG_ADDR_W: MEM-stage destination
- `hazard` out 1: combinational; upstream must hold PC and IF/ID
- `ex_pc`, `ex_val_rn`, `ex_val_rm` out WORD_WIDTH each: registered
- `ex_imm24` out 24, `ex_shift_op` out 12: registered
- `ex_src1`, `ex_src2`, `ex_dst` out REG_ADDR_W each: registered
- `ex_cmd` out 4: registered
- `ex_mem_read`, `ex_mem_write`, `ex_wb_en`, `ex_imm`, `ex_b`, `ex_s` out 1 each: registered

## Operation

**Field extraction**
- `src1 = instr[19:16]`
- `src2 = mem_write ? instr[15:12] : instr[3:0]`
- `dst = instr[15:12]`
- `imm = instr[25]`, `imm24 = instr[23:0]`, `shift_op = instr[11:0]`
- `mode = instr[27:26]`, `opcode = instr[24:21]`, `S = instr[20]`

**Control decode** (`decode_ctrl`)
- mode 00: arithmetic/logic. `ex_cmd` per the package table. `wb_en = 1` except CMP and TST.
- mode 01: LDR when S=1 (`mem_read`, `wb_en`); STR when S=0 (`mem_write`). `cmd = ADD`.
- mode 10: `b = 1`; all other controls are 0.
- Status update: `s = S`, forced to 0 for memory and branch instructions.

**Operand read**
- Two combinational read ports.
- If `wb_en` is set and `wb_dest` equals a read address, the port returns `wb_value` (write-through bypass).
- Address `REG_COUNT-1` returns `pc_in`.
- Writes occur on the rising edge of `clk`; the write to the PC address is ignored.

**Hazard detection**
- src1 is used unless the instruction is a branch, MOV or MVN.
- src2 is used when (mode 00 and `imm == 0`) or `mem_write`.
- `FORWARDING_EN = 0`: `hazard` = (used src matches `exe_dest` and `exe_wb_en`) OR (used src matches `mem_dest` and `mem_wb_en`).
- `FORWARDING_EN = 1`: `hazard` = used src matches `exe_dest` and `exe_mem_read`.
- Sources equal to the PC address never raise `hazard`.
- `hazard` is forced to 0 while `flush` is high.

**ID/EX update priority** (highest first)
1. `rst` low: all outputs cleared.
2. `flush`: bubble.
3. `freeze`: hold all fields.
4. `hazard` or condition fails: bubble.
5. Otherwise: load the decoded bundle.

A bubble clears `ex_mem_read`, `ex_mem_write`, `ex_wb_en`, `ex_b`, `ex_s` and `ex_cmd`. The data fields still load.

## Timing
- Reset: every `ex_*` output is 0 and every register-file entry is 0, applied immediately and asynchronously.
- Latency: an instruction presented in cycle n appears on `ex_*` after edge n+1.
- `hazard` is valid in the same cycle as its inputs. The instruction is re-presented by upstream until `hazard` falls.
- Back-to-back writeback and read of the same register within one cycle returns the new value.
- Reset asserted mid-stall: outputs clear. `hazard` depends only on current inputs.

## Structure
- Package `id_pkg` holds:
  - the `ex_cmd` encodings (MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, CMP=0100 with wb off, TST=0110 with wb off, LDR/STR=0010);
  - the mode constants;
  - the condition-code values.
- Sub-module `decode_ctrl` covers the control decode and the condition check.
- The register file is inline.

## Test plan
- Reset: assert `rst` low mid-run → all `ex_*` outputs 0 and R3 reads 0 afterwards.
- ADD R1,R2,R3 with R2=5, R3=7, cond AL → after one edge: `ex_val_rn = 5`, `ex_val_rm = 7`, `ex_cmd = 0010`, `ex_wb_en = 1`.
- Write-through: `wb_en = 1`, `wb_dest = 2`, `wb_value = 0x55` while decoding with src1 = 2 → `ex_val_rn = 0x55`.
- RAW hazard, `FORWARDING_EN = 0`, `exe_dest = 2`, `exe_wb_en = 1`, instruction reads R2 → `hazard = 1` and a bubble is loaded. With `FORWARDING_EN = 1` and `exe_mem_read = 0` → `hazard = 0`.
- Condition fail: EQ condition with Z=0 → `ex_wb_en = 0`, `ex_cmd = 0`. `freeze` then holds the prior bundle for 3 cycles unchanged.
- `flush` and `freeze` asserted together → bubble loaded and `hazard = 0`.
